// File: rtl/lpc_hexdump_pkg.sv
// Shared constants for the LPC record hex-dump formatter: FSM encodings,
// ASCII literals, record field offsets and line lengths.
package lpc_hexdump_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 8;
  localparam int CYC_LSB  = 0;

  // Bytes per line for each CR / sequence-prefix combination.
  localparam int LINE_LEN_LF     = 14;
  localparam int LINE_LEN_CR     = 15;
  localparam int LINE_LEN_LF_SEQ = 17;
  localparam int LINE_LEN_CR_SEQ = 18;

endpackage

// File: rtl/nibble_to_hex_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter.
module nibble_to_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h37 + {4'h0, nibble});

endmodule

// File: rtl/lpc_record_hexdump.sv
// Pops one 48-bit LPC record at a time and sends it as an ASCII hex text line
// over the uart_tx handshake. Define HEXDUMP_SEQ_EN for an 8-bit line-number prefix.
module lpc_record_hexdump
  import lpc_hexdump_pkg::*;
#(
  parameter int DW          = 48,
  parameter bit LINE_END_CR = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read_empty,
  output logic          read_clock_enable,
  input  logic [DW-1:0] read_data,
  input  logic          uart_ready,
  output logic          uart_clock_enable,
  output logic [7:0]    uart_data
);

`ifdef HEXDUMP_SEQ_EN
  localparam int PFX = 3;
  localparam int LEN = LINE_END_CR ? LINE_LEN_CR_SEQ : LINE_LEN_LF_SEQ;
`else
  localparam int PFX = 0;
  localparam int LEN = LINE_END_CR ? LINE_LEN_CR : LINE_LEN_LF;
`endif
  localparam logic [4:0] LAST = 5'(LEN - 1);

  logic [2:0]    state;
  logic [4:0]    idx;
  logic [DW-1:0] rec;
`ifdef HEXDUMP_SEQ_EN
  logic [7:0]    seq;
`endif

  logic [31:0] addr;
  logic [7:0]  data;
  logic [3:0]  cyc;
  logic        unused_rsvd;

  assign addr        = rec[ADDR_LSB +: 32];
  assign data        = rec[DATA_LSB +: 8];
  assign cyc         = rec[CYC_LSB +: 4];
  assign unused_rsvd = ^rec[7:4];

  logic [4:0] pos;
  logic [3:0] nib;
  logic       use_hex;
  logic [7:0] lit;
  logic [7:0] hex_char;
  logic [7:0] ch;

  // Character select: one shared converter behind a nibble mux keyed by byte index.
  always_comb begin
    nib     = 4'h0;
    use_hex = 1'b0;
    lit     = LF;
    pos     = idx - 5'(PFX);
`ifdef HEXDUMP_SEQ_EN
    if (idx == 5'd0) begin
      use_hex = 1'b1;
      nib     = seq[7:4];
    end else if (idx == 5'd1) begin
      use_hex = 1'b1;
      nib     = seq[3:0];
    end else if (idx == 5'd2) begin
      lit = SPACE;
    end else
`endif
    begin
      case (pos)
        5'd0: begin
          use_hex = 1'b1;
          nib     = cyc;
        end
        5'd1, 5'd10: lit = SPACE;
        5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
          use_hex = 1'b1;
          nib     = 4'(addr >> {5'd9 - pos, 2'b00});
        end
        5'd11: begin
          use_hex = 1'b1;
          nib     = data[7:4];
        end
        5'd12: begin
          use_hex = 1'b1;
          nib     = data[3:0];
        end
        5'd13:   lit = LINE_END_CR ? CR : LF;
        default: lit = LF;
      endcase
    end
  end

  nibble_to_hex_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_char)
  );

  assign ch                = use_hex ? hex_char : lit;
  assign read_clock_enable = (state == FETCH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      idx               <= 5'd0;
      rec               <= '0;
      uart_data         <= 8'h00;
      uart_clock_enable <= 1'b0;
`ifdef HEXDUMP_SEQ_EN
      seq               <= 8'h00;
`endif
    end else begin
      uart_clock_enable <= 1'b0;
      case (state)
        IDLE:  if (!read_empty) state <= FETCH;
        FETCH: state <= LATCH;
        LATCH: begin
          rec   <= read_data;
          idx   <= 5'd0;
          state <= SEND;
        end
        SEND: if (uart_ready) begin
          uart_data         <= ch;
          uart_clock_enable <= 1'b1;
          state             <= HOLD;
        end
        // uart_tx needs a cycle to drop ready after the strobe.
        HOLD: state <= ACK;
        ACK: if (uart_ready) begin
          if (idx == LAST) begin
            state <= IDLE;
`ifdef HEXDUMP_SEQ_EN
            seq   <= seq + 8'd1;
`endif
          end else begin
            idx   <= idx + 5'd1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lpc_record_hexdump.md
Name: lpc_record_hexdump

Overview:
Downstream consumer of the 48-bit LPC record ringbuffer; feeds the UART transmitter. It pops one record at a time and renders it as a fixed-width uppercase ASCII-hex text line, for example "2 00000080 5A\r\n". Lines go out byte-by-byte over the uart_tx ready/clock-enable handshake. It runs in the ext_clock domain and replaces the raw binary mem2serial path when a human-readable capture is wanted.

Parameters:
DW, 48, record width; fixed layout: [47:16] addr, [15:8] data, [7:4] reserved, [3:0] cyctype_dir.
LINE_END_CR, 1, 1 ends each line with "\r\n"; 0 ends it with "\n" only.

Ports:
clock  input  1  system clock (ext_clock domain).
reset  input  1  asynchronous, active-low reset.
read_empty  input  1  ringbuffer empty flag.
read_clock_enable  output  1  one-cycle pop strobe to the ringbuffer.
read_data  input  48  ringbuffer output; valid the cycle after read_clock_enable.
uart_ready  input  1  uart_tx is idle and can accept a byte.
uart_clock_enable  output  1  one-cycle strobe; uart_tx latches uart_data.
uart_data  output  8  byte to transmit.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; read_clock_enable=0, uart_clock_enable=0, uart_data=8'h00; byte index=0; record register=0. Any partial line is discarded; no completion of the line after release.
- States:
  - IDLE: if !read_empty, go to FETCH.
  - FETCH: read_clock_enable=1 for exactly one cycle; go to LATCH.
  - LATCH: capture read_data into the record register; byte index=0; go to SEND.
  - SEND: wait until uart_ready=1. Then drive uart_data=char(index) and uart_clock_enable=1 for one cycle; go to HOLD.
  - HOLD: one cycle, uart_ready is ignored (covers uart_tx ready deassert latency); go to ACK.
  - ACK: wait for uart_ready=1. If index==last, go to IDLE; otherwise index+1 and go to SEND.
- Line layout, index order:
  - 0: hex(cyctype_dir)
  - 1: 0x20
  - 2..9: hex(addr[31:28]) .. hex(addr[3:0])
  - 10: 0x20
  - 11..12: hex(data[7:4]), hex(data[3:0])
  - 13: 0x0D (only if LINE_END_CR)
  - last: 0x0A
  - 15 bytes with CR, 14 without. Reserved bits [7:4] are never printed.
- hex(n): n<10 gives 0x30+n; otherwise 0x37+n (uppercase A-F).
- Never more than one record in flight. read_clock_enable never asserts while read_empty=1, nor outside FETCH.
- Empty asserting during SEND/HOLD/ACK has no effect on the current line.
- Minimum inter-line gap: IDLE->FETCH->LATCH = 3 cycles after the last ACK exit.
- uart_data holds its value between strobes. uart_clock_enable is never asserted on consecutive cycles.
- uart_ready stuck low stalls in SEND/ACK indefinitely; no timeout.

Optional Feature:
Macro HEXDUMP_SEQ_EN.
- Defined: an 8-bit line counter (reset 0x00) is prefixed as two hex chars plus 0x20 before index 0, so lines grow by 3 bytes. The counter increments on ACK exit of the last byte and wraps 0xFF->0x00. Example: "07 2 00000080 5A\r\n".
- Undefined: no counter flops, no prefix; layout exactly as above.

Decomposition:
- Package lpc_hexdump_pkg holds:
  - state enum (IDLE, FETCH, LATCH, SEND, HOLD, ACK)
  - ASCII constants SPACE=0x20, CR=0x0D, LF=0x0A
  - field offset constants ADDR_LSB=16, DATA_LSB=8, CYC_LSB=0
  - LINE_LEN constants for each CR/SEQ combination
- Sub-module nibble_to_hex_ascii: 4-bit in, 8-bit out, purely combinational. It is instantiated once, fed by a nibble mux indexed by byte index.

Test Plan:
- Record {addr=32'h00000080, data=8'h5A, cyctype_dir=4'h2}, uart_ready always 1 -> bytes 32 20 30 30 30 30 30 30 38 30 20 35 41 0D 0A; exactly one read_clock_enable pulse.
- read_empty held 1 for 100 cycles -> read_clock_enable and uart_clock_enable stay 0; uart_data stays 0x00.
- Two queued records {FFFFFFFF,FF,F} and {DEADBEEF,01,0} -> "F FFFFFFFF FF\r\n" then "0 DEADBEEF 01\r\n"; second pop occurs only after the first line's final ACK.
- uart_ready emulates a 10-cycle busy period after each strobe -> exactly 15 strobes per line, each only when uart_ready=1; no byte dropped or repeated.
- Assert reset after byte 5 of a line -> outputs return to reset values immediately. After release with read_empty=1, nothing is transmitted; the next pushed record starts at byte 0.
- HEXDUMP_SEQ_EN defined, 257 records -> prefixes run "00 ".."FF ", then "00 " on line 257.
